// File: rtl/im_fetch.sv
// im_fetch: 32x15 instruction memory with a boot-time clear, registered fetch and JMP delay-slot flush.
// Optional feature macro: IM_JCOND_EN enables conditional jumps (JEQ/JNE/JGT/JLT) on the z/n flags.
module im_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pc,
  input  logic        z,
  input  logic        n,
  input  logic        prog_we,
  input  logic [4:0]  prog_addr,
  input  logic [14:0] prog_data,
  output logic [14:0] instr,
  output logic [7:0]  dataIM,
  output logic        l,
  output logic        valid,
  output logic        ready
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [6:0] OP_JMP = 7'b1001101;

  state_t      state;
  state_t      nextState;
  logic [4:0]  clearCnt;
  logic [14:0] mem [0:31];
  logic        flush;
  logic        jump;
  logic [6:0]  opcode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (state == CLEAR && clearCnt == 5'd31) nextState = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              clearCnt <= 5'd0;
    else if (state == CLEAR) clearCnt <= clearCnt + 5'd1;
  end

  // Memory has no reset; the CLEAR walk zeroes it and locks out programming meanwhile.
  always_ff @(posedge clk) begin
    if (state == CLEAR)  mem[clearCnt]  <= '0;
    else if (prog_we)    mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                instr <= '0;
    else if (state == CLEAR)   instr <= '0;
    else if (pc[7:5] != 3'b0)  instr <= '0;
    else                       instr <= mem[pc[4:0]];
  end

  // A taken jump marks the next fetched word as a delay slot to be squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush <= 1'b0;
    else        flush <= (state == RUN) && l;
  end

  assign opcode = instr[14:8];
  assign dataIM = instr[7:0];
  assign ready  = (state == RUN);
  assign valid  = (state == RUN) && !flush;

`ifdef IM_JCOND_EN
  always_comb begin
    jump = 1'b0;
    case (opcode)
      OP_JMP:     jump = 1'b1;
      7'b1001110: jump = z;
      7'b1001111: jump = !z;
      7'b1010000: jump = !z && !n;
      7'b1010001: jump = n;
      default:    jump = 1'b0;
    endcase
  end
`else
  logic unusedFlags;
  assign unusedFlags = z ^ n;

  always_comb begin
    jump = 1'b0;
    if (opcode == OP_JMP) jump = 1'b1;
  end
`endif

  assign l = valid && jump;

endmodule

// File: tb/tb_im_fetch.sv
// tb_im_fetch: directed scoreboard bench for im_fetch (boot clear, fetch, jumps, flush, resets).
module tb_im_fetch;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pc;
  logic        z;
  logic        n;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [14:0] prog_data;
  logic [14:0] instr;
  logic [7:0]  dataIM;
  logic        l;
  logic        valid;
  logic        ready;

  typedef struct {
    logic [14:0] instr;
    logic        valid;
    logic        l;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef IM_JCOND_EN
  localparam bit JC = 1'b1;
`else
  localparam bit JC = 1'b0;
`endif

  localparam logic [6:0] JMP = 7'b1001101;
  localparam logic [6:0] JEQ = 7'b1001110;

  im_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .z(z), .n(n),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr(instr), .dataIM(dataIM), .l(l), .valid(valid), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs and record what the fetch stage must show after the next edge.
  task automatic applyStimulus(input logic [7:0] pcV, input logic weV, input logic [4:0] addrV,
                               input logic [14:0] dataV, input logic zV, input logic nV,
                               input logic [14:0] expInstr, input logic expValid,
                               input logic expL, input string tag);
    exp_t e;
    pc = pcV; prog_we = weV; prog_addr = addrV; prog_data = dataV; z = zV; n = nV;
    e.instr = expInstr; e.valid = expValid; e.l = expL; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sbEmpty", 15'd1, 15'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".instr"}, instr, e.instr);
      chk({e.tag, ".dataIM"}, {7'd0, dataIM}, {7'd0, e.instr[7:0]});
      chk({e.tag, ".valid"}, {14'd0, valid}, {14'd0, e.valid});
      chk({e.tag, ".l"}, {14'd0, l}, {14'd0, e.l});
      chk({e.tag, ".ready"}, {14'd0, ready}, 15'd1);
    end
  endtask

  task automatic step(input logic [7:0] pcV, input logic weV, input logic [4:0] addrV,
                      input logic [14:0] dataV, input logic zV, input logic nV,
                      input logic [14:0] expInstr, input logic expValid,
                      input logic expL, input string tag);
    applyStimulus(pcV, weV, addrV, dataV, zV, nV, expInstr, expValid, expL, tag);
    checkOutput();
  endtask

  task automatic checkIdle(input string tag);
    chk({tag, ".instr"}, instr, 15'd0);
    chk({tag, ".valid"}, {14'd0, valid}, 15'd0);
    chk({tag, ".l"}, {14'd0, l}, 15'd0);
    chk({tag, ".ready"}, {14'd0, ready}, 15'd0);
  endtask

  // Called on the negedge where rst_n has just been released; returns on the first ready negedge.
  task automatic waitClear(input string tag);
    int cnt = 0;
    bit sawActive = 0;
    while (!ready && cnt < 100) begin
      if (valid || l || instr != 15'd0) sawActive = 1;
      cnt++;
      @(negedge clk);
    end
    chk({tag, ".cycles"}, cnt[14:0], 15'd32);
    chk({tag, ".quiet"}, {14'd0, sawActive}, 15'd0);
  endtask

  initial begin
    rst_n = 1'b0; pc = '0; z = 1'b0; n = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (2) @(negedge clk);
    checkIdle("reset");

    // Programming attempted during CLEAR must be ignored.
    prog_we = 1'b1; prog_addr = 5'd3; prog_data = 15'h7FFF;
    rst_n = 1'b1;
    waitClear("clear1");
    prog_we = 1'b0;

    for (int i = 0; i < 32; i++) step(i[7:0], 1'b0, 5'd0, 15'd0, 1'b0, 1'b0, 15'd0, 1'b1, 1'b0, "zeroRead");

    step(8'd0, 1'b1, 5'd3, 15'h1234, 1'b0, 1'b0, 15'd0, 1'b1, 1'b0, "wr3");
    step(8'd3, 1'b0, 5'd0, 15'd0, 1'b0, 1'b0, 15'h1234, 1'b1, 1'b0, "rd3");

    step(8'd0, 1'b1, 5'd5, {JMP, 8'h0A}, 1'b0, 1'b0, 15'd0, 1'b1, 1'b0, "wr5");
    step(8'd0, 1'b1, 5'd6, {JMP, 8'h0B}, 1'b0, 1'b0, 15'd0, 1'b1, 1'b0, "wr6");
    step(8'd5, 1'b0, 5'd0, 15'd0, 1'b0, 1'b0, {JMP, 8'h0A}, 1'b1, 1'b1, "jmp");
    step(8'd6, 1'b0, 5'd0, 15'd0, 1'b0, 1'b0, {JMP, 8'h0B}, 1'b0, 1'b0, "slot");
    step(8'd0, 1'b0, 5'd0, 15'd0, 1'b0, 1'b0, 15'd0, 1'b1, 1'b0, "afterSlot");

    step(8'd0, 1'b1, 5'd7, {JEQ, 8'h02}, 1'b0, 1'b0, 15'd0, 1'b1, 1'b0, "wr7");
    step(8'd7, 1'b0, 5'd0, 15'd0, 1'b1, 1'b0, {JEQ, 8'h02}, 1'b1, JC, "jeqTaken");
    step(8'd0, 1'b0, 5'd0, 15'd0, 1'b0, 1'b0, 15'd0, !JC, 1'b0, "jeqSlot");
    step(8'd7, 1'b0, 5'd0, 15'd0, 1'b0, 1'b0, {JEQ, 8'h02}, 1'b1, 1'b0, "jeqNot");
    step(8'd0, 1'b0, 5'd0, 15'd0, 1'b0, 1'b0, 15'd0, 1'b1, 1'b0, "jeqAfter");

    step(8'd9, 1'b1, 5'd9, 15'h4321, 1'b0, 1'b0, 15'd0, 1'b1, 1'b0, "rbwOld");
    step(8'd9, 1'b0, 5'd0, 15'd0, 1'b0, 1'b0, 15'h4321, 1'b1, 1'b0, "rbwNew");
    step(8'h25, 1'b0, 5'd0, 15'd0, 1'b0, 1'b0, 15'd0, 1'b1, 1'b0, "highPc");

    // Reset mid-CLEAR restarts the full clear.
    rst_n = 1'b0;
    #1 checkIdle("rstRun");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1 checkIdle("rstClear");
    @(negedge clk);
    rst_n = 1'b1;
    waitClear("clear2");
    step(8'd3, 1'b0, 5'd0, 15'd0, 1'b0, 1'b0, 15'd0, 1'b1, 1'b0, "rezero3");

    // Reset while a JMP is asserting l.
    step(8'd0, 1'b1, 5'd5, {JMP, 8'h0A}, 1'b0, 1'b0, 15'd0, 1'b1, 1'b0, "wr5b");
    step(8'd5, 1'b0, 5'd0, 15'd0, 1'b0, 1'b0, {JMP, 8'h0A}, 1'b1, 1'b1, "jmpB");
    rst_n = 1'b0;
    #1 checkIdle("rstJmp");
    @(negedge clk);
    rst_n = 1'b1;
    waitClear("clear3");
    step(8'd5, 1'b0, 5'd0, 15'd0, 1'b0, 1'b0, 15'd0, 1'b1, 1'b0, "rezero5");

    chk("sbDrained", sb.size(), 15'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
